// File: rtl/iob_cache_refill_pkg.sv
// Shared definitions for the cache line refill engine: FSM encoding, line geometry
// and address field position helpers.
package iob_cache_refill_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StWait   = 2'd2,
    StCommit = 2'd3
  } refill_state_e;

  localparam int unsigned WORDS_PER_LINE = 4;

  // Back-end word address layout is {tag, line, word offset}.
  function automatic int unsigned line_lsb(input int unsigned word_off_w);
    return word_off_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned nlines_w,
                                          input int unsigned word_off_w);
    return nlines_w + word_off_w;
  endfunction

endpackage

// File: rtl/iob_cache_lowest_onehot.sv
// Victim sanitizer: keeps the lowest set bit of the select; an empty select maps to way 0,
// so the result is always exactly one-hot.
module iob_cache_lowest_onehot #(
  parameter int unsigned N_WAYS  = 4,
  parameter int unsigned NWAYS_W = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] sel_i,
  output logic [N_WAYS-1:0] onehot_o
);

  logic [NWAYS_W-1:0] idx;

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (sel_i[i]) idx = NWAYS_W'(i);
    end
  end

  always_comb begin
    onehot_o      = '0;
    onehot_o[idx] = 1'b1;
  end

endmodule

// File: rtl/iob_cache_line_refill.sv
// Read-miss line refill: fetches a whole line from the back end into the victim way, then
// writes tag/valid and marks the way most recently used. Optional IOB_CACHE_CRITICAL_WORD_FIRST_EN.
module iob_cache_line_refill
  import iob_cache_refill_pkg::*;
#(
  parameter int unsigned N_WAYS     = 4,
  parameter int unsigned NWAYS_W    = $clog2(N_WAYS),
  parameter int unsigned NLINES_W   = 7,
  parameter int unsigned WORD_OFF_W = $clog2(WORDS_PER_LINE),
  parameter int unsigned TAG_W      = 16,
  parameter int unsigned BE_DATA_W  = 32,
  parameter int unsigned BE_ADDR_W  = TAG_W + NLINES_W + WORD_OFF_W
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic                           miss_req_i,
  input  logic [BE_ADDR_W-1:0]           miss_addr_i,
  input  logic [N_WAYS-1:0]              way_select_i,
  output logic                           miss_ack_o,
  output logic                           busy_o,
  output logic                           be_valid_o,
  output logic [BE_ADDR_W-1:0]           be_addr_o,
  input  logic                           be_ready_i,
  input  logic                           be_rvalid_i,
  input  logic [BE_DATA_W-1:0]           be_rdata_i,
  output logic [N_WAYS-1:0]              data_we_o,
  output logic [NLINES_W+WORD_OFF_W-1:0] data_addr_o,
  output logic [BE_DATA_W-1:0]           data_wdata_o,
  output logic [N_WAYS-1:0]              tag_we_o,
  output logic [NLINES_W-1:0]            tag_line_o,
  output logic [TAG_W-1:0]               tag_o,
  output logic                           repl_we_o,
  output logic [N_WAYS-1:0]              repl_way_hit_o,
  output logic [NLINES_W-1:0]            repl_line_o,
  output logic                           crit_rdy_o
);

`ifdef IOB_CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  localparam int unsigned LINE_LSB = line_lsb(WORD_OFF_W);
  localparam int unsigned TAG_LSB  = tag_lsb(NLINES_W, WORD_OFF_W);

  refill_state_e         state_q, state_d;
  logic [WORD_OFF_W-1:0] cnt_q, cnt_d;
  logic [WORD_OFF_W-1:0] beats_q, beats_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [NLINES_W-1:0]   line_q, line_d;
  logic [N_WAYS-1:0]     way_q, way_d;
  logic [N_WAYS-1:0]     way_clean;

  iob_cache_lowest_onehot #(
    .N_WAYS  (N_WAYS),
    .NWAYS_W (NWAYS_W)
  ) u_lowest_onehot (
    .sel_i    (way_select_i),
    .onehot_o (way_clean)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beats_q <= '0;
      tag_q   <= '0;
      line_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      way_q   <= way_d;
    end
  end

  // cnt_q is the word address (may start mid-line and wrap); beats_q counts words
  // transferred, so the line completes after a full lap regardless of start offset.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    beats_d        = beats_q;
    tag_d          = tag_q;
    line_d         = line_q;
    way_d          = way_q;
    be_valid_o     = 1'b0;
    data_we_o      = '0;
    data_wdata_o   = '0;
    crit_rdy_o     = 1'b0;
    tag_we_o       = '0;
    repl_we_o      = 1'b0;
    repl_way_hit_o = '0;
    miss_ack_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss_req_i) begin
          tag_d   = miss_addr_i[BE_ADDR_W-1:TAG_LSB];
          line_d  = miss_addr_i[TAG_LSB-1:LINE_LSB];
          way_d   = way_clean;
          cnt_d   = CRIT_FIRST ? miss_addr_i[WORD_OFF_W-1:0] : '0;
          beats_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        be_valid_o = 1'b1;
        if (be_ready_i) state_d = StWait;
      end
      StWait: begin
        if (be_rvalid_i) begin
          data_we_o    = way_q;
          data_wdata_o = be_rdata_i;
          crit_rdy_o   = CRIT_FIRST && (beats_q == '0);
          cnt_d        = cnt_q + WORD_OFF_W'(1);
          beats_d      = beats_q + WORD_OFF_W'(1);
          state_d      = (&beats_q) ? StCommit : StReq;
        end
      end
      StCommit: begin
        tag_we_o       = way_q;
        repl_we_o      = 1'b1;
        repl_way_hit_o = way_q;
        miss_ack_o     = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign be_addr_o   = {tag_q, line_q, cnt_q};
  assign data_addr_o = {line_q, cnt_q};
  assign tag_line_o  = line_q;
  assign tag_o       = tag_q;
  assign repl_line_o = line_q;

endmodule

// File: tb/tb_iob_cache_line_refill.sv
// Self-checking bench for iob_cache_line_refill: a line-level model of expected writes and
// commits, a back-end responder, and directed refill scenarios.
module tb_iob_cache_line_refill;

`ifdef IOB_CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        miss_req;
  logic [24:0] miss_addr;
  logic [3:0]  way_select;
  logic        miss_ack_o, busy_o, be_valid_o;
  logic [24:0] be_addr_o;
  logic        be_ready, be_rvalid;
  logic [31:0] be_rdata;
  logic [3:0]  data_we_o;
  logic [8:0]  data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  tag_we_o;
  logic [6:0]  tag_line_o;
  logic [15:0] tag_o;
  logic        repl_we_o;
  logic [3:0]  repl_way_hit_o;
  logic [6:0]  repl_line_o;
  logic        crit_rdy_o;

  always #5 clk = ~clk;

  iob_cache_line_refill dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .miss_req_i     (miss_req),
    .miss_addr_i    (miss_addr),
    .way_select_i   (way_select),
    .miss_ack_o     (miss_ack_o),
    .busy_o         (busy_o),
    .be_valid_o     (be_valid_o),
    .be_addr_o      (be_addr_o),
    .be_ready_i     (be_ready),
    .be_rvalid_i    (be_rvalid),
    .be_rdata_i     (be_rdata),
    .data_we_o      (data_we_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .tag_we_o       (tag_we_o),
    .tag_line_o     (tag_line_o),
    .tag_o          (tag_o),
    .repl_we_o      (repl_we_o),
    .repl_way_hit_o (repl_way_hit_o),
    .repl_line_o    (repl_line_o),
    .crit_rdy_o     (crit_rdy_o)
  );

  typedef struct {
    logic [3:0]  way;
    logic [8:0]  addr;
    logic [31:0] data;
    bit          first;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  wr_t         exp_q[$];
  logic [15:0] exp_tag;
  logic [6:0]  exp_line;
  logic [3:0]  exp_way;
  bit          commit_pending = 1'b0;
  int          req_cyc = 0;
  int          ack_cyc = 0;
  int          crit_cnt = 0;
  int          wr_cnt = 0;
  logic [1:0]  first_word = '0;
  logic [31:0] first_data = '0;
  logic [3:0]  last_way = '0;
  bit          spur_en = 1'b0;
  int          stall_word = 0;
  int          stall_left = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_data(input logic [6:0] line, input logic [1:0] w);
    return 32'h0000_00A0 + {9'd0, line, 16'd0} + {30'd0, w};
  endfunction

  function automatic logic [3:0] pick_way(input logic [3:0] sel);
    for (int i = 0; i < 4; i++) if (sel[i]) return 4'b0001 << i;
    return 4'b0001;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Back end: accepts per be_ready, returns data one cycle after acceptance.
  initial begin
    bit          hs;
    logic [24:0] hs_addr;
    hs = 1'b0;
    hs_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!arst_n) begin
        be_rvalid = 1'b0;
        be_ready  = 1'b1;
      end else begin
        if (hs) begin
          be_rvalid = 1'b1;
          be_rdata  = word_data(hs_addr[8:2], hs_addr[1:0]);
        end else if (spur_en && (be_valid_o || !busy_o)) begin
          be_rvalid = 1'b1;
          be_rdata  = 32'hDEAD_BEEF;
        end else begin
          be_rvalid = 1'b0;
        end
        if (be_valid_o && stall_left > 0 && be_addr_o[1:0] == stall_word[1:0]) begin
          be_ready = 1'b0;
          stall_left--;
        end else begin
          be_ready = 1'b1;
        end
      end
      @(negedge clk);
      hs      = arst_n && be_valid_o && be_ready;
      hs_addr = be_addr_o;
    end
  end

  // Compare process: every observed write/commit/request against the line-level model.
  initial begin
    bit          prev_stall;
    logic [24:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        chk("rst_busy", busy_o, 0);
        chk("rst_be_valid", be_valid_o, 0);
        chk("rst_data_we", data_we_o, 0);
        chk("rst_tag_we", tag_we_o, 0);
        chk("rst_repl_we", repl_we_o, 0);
        chk("rst_ack", miss_ack_o, 0);
        chk("rst_crit", crit_rdy_o, 0);
        prev_stall = 1'b0;
      end else begin
        chk("busy", busy_o, commit_pending && (cyc > req_cyc));
        if (data_we_o != 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", data_we_o, 0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_way", data_we_o, e.way);
            chk("wr_addr", data_addr_o, e.addr);
            chk("wr_data", data_wdata_o, e.data);
            chk("crit_rdy", crit_rdy_o, CWF && e.first);
            if (e.first) begin
              first_word = data_addr_o[1:0];
              first_data = data_wdata_o;
            end
            if (crit_rdy_o) crit_cnt++;
            last_way = data_we_o;
            wr_cnt++;
          end
        end else begin
          chk("crit_no_write", crit_rdy_o, 0);
        end
        if (tag_we_o != 0 || repl_we_o || miss_ack_o) begin
          chk("commit_expected", commit_pending, 1);
          chk("commit_after_line", exp_q.size(), 0);
          chk("tag_we", tag_we_o, exp_way);
          chk("tag", tag_o, exp_tag);
          chk("tag_line", tag_line_o, exp_line);
          chk("repl_we", repl_we_o, 1);
          chk("repl_way_hit", repl_way_hit_o, exp_way);
          chk("repl_line", repl_line_o, exp_line);
          chk("miss_ack", miss_ack_o, 1);
          commit_pending = 1'b0;
        end
        if (be_valid_o) begin
          if (exp_q.size() == 0) chk("unexpected_req", be_valid_o, 0);
          else chk("be_addr", be_addr_o, {exp_tag, exp_q[0].addr});
          if (prev_stall) chk("be_addr_hold", be_addr_o, prev_addr);
        end
        prev_stall = be_valid_o && !be_ready;
        prev_addr  = be_addr_o;
      end
    end
  end

  task automatic start_refill(input logic [24:0] addr, input logic [3:0] sel);
    logic [1:0] s;
    @(posedge clk);
    #1;
    s        = CWF ? addr[1:0] : 2'd0;
    exp_tag  = addr[24:9];
    exp_line = addr[8:2];
    exp_way  = pick_way(sel);
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) begin
      wr_t        e;
      logic [1:0] w;
      w       = s + 2'(i);
      e.way   = exp_way;
      e.addr  = {exp_line, w};
      e.data  = word_data(exp_line, w);
      e.first = (i == 0);
      exp_q.push_back(e);
    end
    commit_pending = 1'b1;
    crit_cnt       = 0;
    req_cyc        = cyc;
    miss_req       = 1'b1;
    miss_addr      = addr;
    way_select     = sel;
  endtask

  task automatic wait_ack(input bit toggle);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (miss_ack_o) begin
        done    = 1'b1;
        ack_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (done) miss_req = 1'b0;
      else if (toggle) miss_req = ~miss_req;
    end
    chk("ack_timeout", done, 1);
  endtask

  initial begin
    bit reached;
    arst_n     = 1'b0;
    miss_req   = 1'b0;
    miss_addr  = '0;
    way_select = '0;
    be_ready   = 1'b1;
    be_rvalid  = 1'b0;
    be_rdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_be_addr", be_addr_o, 0);
    chk("rst_tag_o", tag_o, 0);
    #1;
    arst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic refill, 10-cycle minimum latency inclusive of request and ack cycles.
    start_refill({16'h0001, 7'h12, 2'd0}, 4'b0100);
    wait_ack(1'b0);
    chk("basic_latency", ack_cyc - req_cyc + 1, 10);
    chk("basic_way", last_way, 4'b0100);
    chk("basic_first_data", first_data, 32'h0012_00A0);

    // Back-pressure on word 2 for five cycles.
    stall_word = 2;
    stall_left = 5;
    start_refill({16'hBEEF, 7'h05, 2'd0}, 4'b0001);
    wait_ack(1'b0);
    chk("bp_latency", ack_cyc - req_cyc + 1, 15);
    chk("bp_stall_consumed", stall_left, 0);

    // Non-one-hot victims.
    start_refill({16'h1234, 7'h7F, 2'd0}, 4'b0110);
    wait_ack(1'b0);
    chk("victim_0110", last_way, 4'b0010);
    start_refill({16'h4321, 7'h00, 2'd0}, 4'b0000);
    wait_ack(1'b0);
    chk("victim_0000", last_way, 4'b0001);

    // Reset after two words: abort with no tag/replacement write.
    wr_cnt = 0;
    start_refill({16'h0F0F, 7'h33, 2'd0}, 4'b1000);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      @(posedge clk);
      if (wr_cnt >= 2) reached = 1'b1;
    end
    chk("rst_two_words_seen", reached, 1);
    #3;
    arst_n         = 1'b0;
    miss_req       = 1'b0;
    commit_pending = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_be_valid", be_valid_o, 0);
    chk("abort_tag_we", tag_we_o, 0);
    chk("abort_repl_we", repl_we_o, 0);
    repeat (2) @(posedge clk);
    #2;
    arst_n = 1'b1;
    repeat (5) @(posedge clk);
    start_refill({16'h0F0F, 7'h33, 2'd0}, 4'b1000);
    wait_ack(1'b0);
    chk("post_reset_latency", ack_cyc - req_cyc + 1, 10);

    // Spurious rvalid in REQ/IDLE and miss_req toggling while busy.
    spur_en = 1'b1;
    start_refill({16'hCAFE, 7'h01, 2'd0}, 4'b0010);
    wait_ack(1'b1);
    spur_en = 1'b0;
    chk("spur_latency", ack_cyc - req_cyc + 1, 10);
    repeat (3) @(posedge clk);

    // Start offset 2: wrapped order with critical word first, else sequential.
    start_refill({16'h00AA, 7'h44, 2'd2}, 4'b0100);
    wait_ack(1'b0);
    chk("order_first_word", first_word, CWF ? 2'd2 : 2'd0);
    chk("crit_pulses", crit_cnt, CWF ? 1 : 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
